blake2_msg_ctrl: RTL and testbench

Sequencer placed in front of the blake2 compression core. It accepts one message as a byte stream with a valid/ready handshake, cuts it into BB-byte blocks, and zero-pads the final block. It drives the core's byte-load interface, including the first/last block flags and the total length, and paces blocks around the core's compression time. It then forwards the NN-byte digest streamed back by the core.

---
 rtl/blake2_msg_ctrl.sv | 164 ++++++++++++++++
 tb/tb_blake2_msg_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_msg_ctrl.sv
// rtl/blake2_msg_ctrl.sv - cuts a message byte stream into zero-padded blocks for a blake2 core
// and forwards the digest bytes the core streams back.
module blake2_msg_ctrl #(
    parameter int BB       = 128,
    parameter int W        = 64,
    parameter int LL_W     = 64,
    parameter int F_CYCLES = 100,
    parameter int NN_W     = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [LL_W-1:0]          ll_i,
    input  logic [NN_W-1:0]          nn_i,
    output logic                     busy_o,
    input  logic                     msg_valid_i,
    output logic                     msg_ready_o,
    input  logic [7:0]               msg_data_i,
    output logic                     core_data_v_o,
    output logic [$clog2(BB)-1:0]    core_data_idx_o,
    output logic [7:0]               core_data_o,
    output logic                     core_block_first_o,
    output logic                     core_block_last_o,
    output logic [2*W-1:0]           core_ll_o,
    output logic [$clog2(W+1)-1:0]   core_nn_o,
    output logic [$clog2(W+1)-1:0]   core_kk_o,
    input  logic                     core_finished_i,
    input  logic [7:0]               core_h_i,
    output logic                     hash_valid_o,
    output logic [7:0]               hash_data_o,
    output logic                     hash_last_o,
    output logic                     done_o
);
    localparam int IDX_W = $clog2(BB);
    localparam int NO_W  = $clog2(W+1);
    localparam int GAP_W = $clog2(F_CYCLES+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BB-1);
    localparam logic [LL_W-1:0]  BB_LL    = LL_W'(BB);

    typedef enum logic [2:0] {IDLE, LOAD, PAD, GAP, WAIT_H, DRAIN} state_t;
    state_t r_state, w_state_next;

    logic [LL_W-1:0]  r_ll;
    logic [LL_W-1:0]  r_rem;
    logic [NN_W-1:0]  r_nn;
    logic [NN_W-1:0]  r_hcnt;
    logic [IDX_W-1:0] r_pos;
    logic [GAP_W-1:0] r_gap;
    logic             w_hs;
    logic             w_start;
    logic             w_block_full;
    logic             w_gap_end;
    logic             w_hash_end;

    // done_o is raised from IDLE's predecessor edge, so busy must cover it explicitly
    assign busy_o       = (r_state != IDLE) || done_o;
    assign msg_ready_o  = (r_state == LOAD) && (r_rem != '0);
    assign w_hs         = msg_valid_i && msg_ready_o;
    assign w_start      = start_i && !busy_o;
    assign w_block_full = (r_pos == LAST_IDX);
    assign w_gap_end    = (r_gap == GAP_W'(F_CYCLES-1));
    assign w_hash_end   = (r_hcnt == r_nn);

    assign core_ll_o = (2*W)'(r_ll);
    assign core_nn_o = NO_W'(r_nn);
    assign core_kk_o = '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_start) w_state_next = LOAD;
            LOAD: begin
                if (r_rem == '0)
                    w_state_next = PAD;
                else if (w_hs && w_block_full)
                    w_state_next = core_block_last_o ? WAIT_H : GAP;
                else if (w_hs && r_rem == LL_W'(1))
                    w_state_next = PAD;
            end
            PAD:    if (w_block_full) w_state_next = WAIT_H;
            GAP:    if (w_gap_end) w_state_next = LOAD;
            WAIT_H: if (core_finished_i) w_state_next = DRAIN;
            DRAIN:  if (w_hash_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ll               <= '0;
            r_rem              <= '0;
            r_nn               <= '0;
            r_hcnt             <= '0;
            r_pos              <= '0;
            r_gap              <= '0;
            core_data_v_o      <= 1'b0;
            core_data_idx_o    <= '0;
            core_data_o        <= '0;
            core_block_first_o <= 1'b0;
            core_block_last_o  <= 1'b0;
            hash_valid_o       <= 1'b0;
            hash_data_o        <= '0;
            hash_last_o        <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            core_data_v_o <= 1'b0;
            hash_valid_o  <= 1'b0;
            hash_last_o   <= 1'b0;
            done_o        <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_ll               <= ll_i;
                    r_rem              <= ll_i;
                    r_nn               <= nn_i;
                    r_hcnt             <= '0;
                    r_pos              <= '0;
                    r_gap              <= '0;
                    core_block_first_o <= 1'b1;
                    core_block_last_o  <= (ll_i <= BB_LL);
                end
                LOAD: if (w_hs) begin
                    core_data_v_o   <= 1'b1;
                    core_data_idx_o <= r_pos;
                    core_data_o     <= msg_data_i;
                    r_pos           <= r_pos + 1'b1;
                    r_rem           <= r_rem - 1'b1;
                end
                PAD: begin
                    core_data_v_o   <= 1'b1;
                    core_data_idx_o <= r_pos;
                    core_data_o     <= 8'h00;
                    r_pos           <= r_pos + 1'b1;
                end
                GAP: begin
                    r_gap <= r_gap + 1'b1;
                    if (w_gap_end) begin
                        r_gap              <= '0;
                        r_pos              <= '0;
                        core_block_first_o <= 1'b0;
                        core_block_last_o  <= (r_rem <= BB_LL);
                    end
                end
                DRAIN: begin
                    if (!w_hash_end) begin
                        hash_valid_o <= 1'b1;
                        hash_data_o  <= core_h_i;
                        hash_last_o  <= (r_hcnt == r_nn - NN_W'(1));
                        r_hcnt       <= r_hcnt + 1'b1;
                    end else begin
                        done_o             <= 1'b1;
                        core_block_first_o <= 1'b0;
                        core_block_last_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_blake2_msg_ctrl.sv
// tb/tb_blake2_msg_ctrl.sv - randomized self-checking bench for blake2_msg_ctrl
module tb_blake2_msg_ctrl;
    localparam int BB       = 128;
    localparam int W        = 64;
    localparam int LL_W     = 64;
    localparam int F_CYCLES = 100;
    localparam int NN_W     = 7;
    localparam int NO_W     = $clog2(W+1);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start_i = 1'b0;
    logic [LL_W-1:0]       ll_i = '0;
    logic [NN_W-1:0]       nn_i = '0;
    logic                  busy_o;
    logic                  msg_valid_i = 1'b0;
    logic                  msg_ready_o;
    logic [7:0]            msg_data_i = '0;
    logic                  core_data_v_o;
    logic [$clog2(BB)-1:0] core_data_idx_o;
    logic [7:0]            core_data_o;
    logic                  core_block_first_o;
    logic                  core_block_last_o;
    logic [2*W-1:0]        core_ll_o;
    logic [NO_W-1:0]       core_nn_o;
    logic [NO_W-1:0]       core_kk_o;
    logic                  core_finished_i = 1'b0;
    logic [7:0]            core_h_i = '0;
    logic                  hash_valid_o;
    logic [7:0]            hash_data_o;
    logic                  hash_last_o;
    logic                  done_o;
    logic [172:0]          all_outs;

    blake2_msg_ctrl #(.BB(BB), .W(W), .LL_W(LL_W), .F_CYCLES(F_CYCLES), .NN_W(NN_W)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .ll_i(ll_i), .nn_i(nn_i), .busy_o(busy_o),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
        .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o), .core_data_o(core_data_o),
        .core_block_first_o(core_block_first_o), .core_block_last_o(core_block_last_o),
        .core_ll_o(core_ll_o), .core_nn_o(core_nn_o), .core_kk_o(core_kk_o),
        .core_finished_i(core_finished_i), .core_h_i(core_h_i),
        .hash_valid_o(hash_valid_o), .hash_data_o(hash_data_o), .hash_last_o(hash_last_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    assign all_outs = {busy_o, msg_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
                       core_block_first_o, core_block_last_o, core_ll_o, core_nn_o, core_kk_o,
                       hash_valid_o, hash_data_o, hash_last_o, done_o};

    int total = 0;
    int bad = 0;
    int cyc_now = 0;
    int msg [0:511];
    int dig [0:63];

    int wr_idx_q[$];
    int wr_dat_q[$];
    int wr_flg_q[$];
    int wr_cyc_q[$];
    int h_dat_q[$];
    int h_last_q[$];
    int h_cyc_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int done_busy = 0;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    // Passive observer of both output streams, sampled mid-cycle
    always @(negedge clk) begin
        if (core_data_v_o === 1'b1) begin
            wr_idx_q.push_back(int'(core_data_idx_o));
            wr_dat_q.push_back(int'(core_data_o));
            wr_flg_q.push_back(int'({core_block_first_o, core_block_last_o}));
            wr_cyc_q.push_back(cyc_now);
        end
        if (hash_valid_o === 1'b1) begin
            h_dat_q.push_back(int'(hash_data_o));
            h_last_q.push_back(int'(hash_last_o));
            h_cyc_q.push_back(cyc_now);
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_now;
            done_busy = int'(busy_o);
        end
    end

    task automatic clear_mon();
        wr_idx_q.delete(); wr_dat_q.delete(); wr_flg_q.delete(); wr_cyc_q.delete();
        h_dat_q.delete(); h_last_q.delete(); h_cyc_q.delete();
        done_cnt = 0;
    endtask

    // One complete message: feed bytes, play the core, compare against the block/padding rules
    task automatic run_msg(input string tag, input int ll, input int nn, input int vpct, input bit poke);
        int nblk, sent, cyc, lat_err, rdy_err, low_run, wr_err, pad_err, h_err, fin_cyc, last_byte, last_h;
        int bad_j, got_i, got_d, got_f, exp_i, exp_d, exp_f;
        int gaps[$];
        bit hs_prev, v, gap_ok, lat_ok;
        logic [2*W-1:0] exp_ll;
        nblk = (ll == 0) ? 1 : (ll + BB - 1) / BB;
        exp_ll = (2*W)'(ll);
        for (int i = 0; i < ll; i++) msg[i] = $urandom_range(255);
        for (int i = 0; i < nn; i++) dig[i] = $urandom_range(255);
        clear_mon();
        sent = 0; cyc = 0; lat_err = 0; rdy_err = 0; low_run = 0; hs_prev = 0; last_byte = 0;
        @(negedge clk);
        ll_i = LL_W'(ll); nn_i = NN_W'(nn); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b1 || core_ll_o !== exp_ll || core_nn_o !== NO_W'(nn) || core_kk_o !== '0) begin
            bad++;
            $display("FAIL %s start_latch: busy=%0d ll=%0d nn=%0d kk=%0d expected busy=1 ll=%0d nn=%0d kk=0",
                     tag, busy_o, core_ll_o, core_nn_o, core_kk_o, ll, nn);
        end

        while (wr_dat_q.size() < nblk * BB && cyc < 3000) begin
            if (hs_prev || sent < ll) begin
                if (core_data_v_o !== hs_prev || (hs_prev && int'(core_data_o) != last_byte)) lat_err++;
            end
            if (msg_ready_o === 1'b1 && sent >= ll) rdy_err++;
            if (msg_ready_o !== 1'b1 && sent > 0 && sent < ll) begin
                low_run++;
            end else if (msg_ready_o === 1'b1) begin
                if (low_run > 0) gaps.push_back(low_run);
                low_run = 0;
            end
            v = ($urandom_range(99) < vpct);
            msg_valid_i = v;
            msg_data_i = v ? 8'(msg[sent]) : 8'($urandom);
            start_i = ($urandom_range(15) == 0);
            ll_i = LL_W'({$urandom, $urandom});
            nn_i = NN_W'($urandom);
            hs_prev = v && (msg_ready_o === 1'b1);
            if (hs_prev) begin
                last_byte = msg[sent];
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        msg_valid_i = 1'b0;
        start_i = 1'b0;

        total++;
        if (lat_err != 0) begin
            bad++;
            $display("FAIL %s load_latency: %0d cycles where write strobe/data did not follow the handshake, expected 0", tag, lat_err);
        end
        total++;
        if (rdy_err != 0) begin
            bad++;
            $display("FAIL %s ready_after_msg: ready high on %0d cycles with no bytes left, expected 0", tag, rdy_err);
        end
        gap_ok = (gaps.size() == nblk - 1);
        foreach (gaps[i]) if (gaps[i] != F_CYCLES) gap_ok = 1'b0;
        total++;
        if (!gap_ok) begin
            bad++;
            $display("FAIL %s gap_len: %0d gaps, first=%0d, expected %0d gaps of %0d",
                     tag, gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, nblk - 1, F_CYCLES);
        end

        wr_err = 0; pad_err = 0; bad_j = -1;
        got_i = 0; got_d = 0; got_f = 0; exp_i = 0; exp_d = 0; exp_f = 0;
        if (wr_dat_q.size() == nblk * BB) begin
            for (int j = 0; j < nblk * BB; j++) begin
                int b, ed, ef;
                b = j / BB;
                ed = (j < ll) ? msg[j] : 0;
                ef = ((b == 0) ? 2 : 0) + ((b == nblk - 1) ? 1 : 0);
                if (wr_idx_q[j] != j % BB || wr_dat_q[j] != ed || wr_flg_q[j] != ef) begin
                    if (wr_err == 0) begin
                        bad_j = j; got_i = wr_idx_q[j]; got_d = wr_dat_q[j]; got_f = wr_flg_q[j];
                        exp_i = j % BB; exp_d = ed; exp_f = ef;
                    end
                    wr_err++;
                end
                if (j >= ll && j % BB != 0 && wr_cyc_q[j] != wr_cyc_q[j-1] + 1) pad_err++;
            end
        end else begin
            wr_err = 1;
        end
        total++;
        if (wr_err != 0) begin
            bad++;
            $display("FAIL %s write_stream: writes=%0d bad=%0d at=%0d got idx=%0d data=%0h first_last=%0d expected writes=%0d idx=%0d data=%0h first_last=%0d",
                     tag, wr_dat_q.size(), wr_err, bad_j, got_i, got_d, got_f, nblk * BB, exp_i, exp_d, exp_f);
        end
        total++;
        if (pad_err != 0) begin
            bad++;
            $display("FAIL %s pad_back_to_back: %0d padding writes not on consecutive cycles, expected 0", tag, pad_err);
        end

        repeat ($urandom_range(1, 4)) @(negedge clk);
        fin_cyc = cyc_now;
        core_finished_i = 1'b1;
        for (int k = 0; k < nn; k++) begin
            @(negedge clk);
            core_h_i = 8'(dig[k]);
            start_i = poke && (k == nn / 2);
        end
        @(negedge clk);
        core_finished_i = 1'b0;
        core_h_i = 8'($urandom);
        start_i = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);

        h_err = 0;
        if (h_dat_q.size() != nn) h_err = 1;
        else foreach (h_dat_q[k]) if (h_dat_q[k] != dig[k] || h_last_q[k] != ((k == nn - 1) ? 1 : 0)) h_err++;
        total++;
        if (h_err != 0) begin
            bad++;
            $display("FAIL %s hash_stream: bytes=%0d errors=%0d expected bytes=%0d errors=0", tag, h_dat_q.size(), h_err, nn);
        end
        lat_ok = (h_cyc_q.size() > 0) && (h_cyc_q[0] == fin_cyc + 2);
        foreach (h_cyc_q[k]) if (h_cyc_q[k] != fin_cyc + 2 + k) lat_ok = 1'b0;
        total++;
        if (!lat_ok) begin
            bad++;
            $display("FAIL %s hash_latency: first byte at +%0d cycles, expected +2 and contiguous",
                     tag, (h_cyc_q.size() > 0) ? h_cyc_q[0] - fin_cyc : -1);
        end
        last_h = (h_cyc_q.size() > 0) ? h_cyc_q[h_cyc_q.size() - 1] : -10;
        total++;
        if (done_cnt != 1 || done_busy != 1 || done_cyc != last_h + 1) begin
            bad++;
            $display("FAIL %s done_pulse: count=%0d busy=%0d offset=%0d expected count=1 busy=1 offset=1",
                     tag, done_cnt, done_busy, done_cyc - last_h);
        end
        total++;
        if (busy_o !== 1'b0 || msg_ready_o !== 1'b0 || core_data_v_o !== 1'b0 || core_ll_o !== exp_ll) begin
            bad++;
            $display("FAIL %s idle_after_done: busy=%0d ready=%0d wr=%0d ll=%0d expected 0 0 0 %0d",
                     tag, busy_o, msg_ready_o, core_data_v_o, core_ll_o, ll);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h expected 0", all_outs);
        end
        reset = 1'b0;
        msg_valid_i = 1'b1; msg_data_i = 8'h5a; core_finished_i = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (all_outs !== '0 || wr_dat_q.size() != 0 || h_dat_q.size() != 0) begin
            bad++;
            $display("FAIL idle_ignores_inputs: outs=%0h writes=%0d hash=%0d expected all 0",
                     all_outs, wr_dat_q.size(), h_dat_q.size());
        end
        msg_valid_i = 1'b0; core_finished_i = 1'b0;
    endtask

    task automatic test_empty();
        run_msg("empty", 0, 64, 100, 1'b0);
    endtask

    task automatic test_abc();
        run_msg("abc", 3, 64, 100, 1'b0);
    endtask

    task automatic test_full_block();
        run_msg("full_block", 128, 64, 50, 1'b0);
    endtask

    task automatic test_two_blocks();
        run_msg("two_blocks", 129, 64, 100, 1'b0);
    endtask

    task automatic test_reset_mid();
        int sent, cyc;
        sent = 0; cyc = 0;
        clear_mon();
        @(negedge clk);
        ll_i = LL_W'(200); nn_i = NN_W'(64); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (sent < 41 && cyc < 200) begin
            msg_valid_i = 1'b1;
            msg_data_i = 8'(sent + 1);
            if (msg_ready_o === 1'b1) sent++;
            @(negedge clk);
            cyc++;
        end
        msg_valid_i = 1'b0;
        total++;
        if (core_data_v_o !== 1'b1 || core_data_idx_o !== 7'd40) begin
            bad++;
            $display("FAIL pre_reset_write: v=%0d idx=%0d expected v=1 idx=40", core_data_v_o, core_data_idx_o);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL async_reset: got %0h expected 0", all_outs);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_msg("after_reset", 50, 16, 70, 1'b0);
    endtask

    task automatic test_start_in_drain();
        run_msg("start_in_drain", 20, 32, 100, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++)
            run_msg("random", $urandom_range(1, 300), $urandom_range(1, 64), $urandom_range(30, 100), 1'b1);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_full_block();
        test_two_blocks();
        test_reset_mid();
        test_start_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
